// File: rtl/mem_stage.sv
// mem_stage: RV32I memory-access stage with the MEM/WB pipeline register.
// Issues byte/half/word loads and stores over a valid/ready port. Stalls
// upstream stages while an access is outstanding. Misaligned accesses and
// timed-out accesses are reported through ExcW/ExcCauseW and never retire.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] AluoutM,
    input  logic [31:0] Mem_dataM,
    input  logic [4:0]  rdM,
    input  logic        RegWriteM,
    input  logic        ResultSrcM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_wstrb,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        StallM,
    output logic [31:0] AluoutW,
    output logic [31:0] ReadDataW,
    output logic [4:0]  rdW,
    output logic        RegWriteW,
    output logic        ResultSrcW,
    output logic        ExcW,
    output logic [1:0]  ExcCauseW
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    // Last counter value of WAIT; the access is still live on this cycle.
    localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

    state_t      state, next_state;
    logic [15:0] cnt;
    logic        mem_op, is_load, aligned;
    logic        done, timeout, misal;
    logic [3:0]  lane_strb;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_ext;
    logic        sx;

    // A store wins when both load and store bits are set.
    assign mem_op  = ResultSrcM | MemWriteM;
    assign is_load = ResultSrcM & ~MemWriteM;
    assign aligned = (funct3M[1:0] == 2'b00) ||
                     (funct3M[1:0] == 2'b01 && !AluoutM[0]) ||
                     (funct3M[1]   == 1'b1  && AluoutM[1:0] == 2'b00);

    assign dmem_addr  = {AluoutM[31:2], 2'b00};
    assign dmem_we    = dmem_req & MemWriteM;
    assign dmem_wstrb = MemWriteM ? lane_strb : 4'b0000;

    // Replicate store data across lanes and pick the byte enables for the size.
    always_comb begin
        dmem_wdata = Mem_dataM;
        lane_strb  = 4'b1111;
        case (funct3M[1:0])
            2'b00: begin
                dmem_wdata = {4{Mem_dataM[7:0]}};
                lane_strb  = 4'b0001 << AluoutM[1:0];
            end
            2'b01: begin
                dmem_wdata = {2{Mem_dataM[15:0]}};
                lane_strb  = 4'b0011 << {AluoutM[1], 1'b0};
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half from the returned word and extend it.
    always_comb begin
        sx = ~funct3M[2];
        case (AluoutM[1:0])
            2'b00:   byte_sel = dmem_rdata[7:0];
            2'b01:   byte_sel = dmem_rdata[15:8];
            2'b10:   byte_sel = dmem_rdata[23:16];
            default: byte_sel = dmem_rdata[31:24];
        endcase
        half_sel = AluoutM[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3M[1:0])
            2'b00:   load_ext = {{24{sx & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{16{sx & half_sel[15]}}, half_sel};
            default: load_ext = dmem_rdata;
        endcase
    end

    // Handshake FSM: request, stall and completion/timeout decisions.
    always_comb begin
        next_state = state;
        dmem_req   = 1'b0;
        StallM     = 1'b0;
        done       = 1'b0;
        timeout    = 1'b0;
        misal      = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op && aligned) begin
                    dmem_req = 1'b1;
                    if (dmem_ready) begin
                        done = 1'b1;
                    end else begin
                        StallM     = 1'b1;
                        next_state = WAIT;
                    end
                end else if (mem_op) begin
                    misal = 1'b1;
                end
            end
            WAIT: begin
                // Ready on the limit cycle still completes the access.
                dmem_req = 1'b1;
                if (dmem_ready) begin
                    done       = 1'b1;
                    next_state = IDLE;
                end else if (cnt == LIMIT) begin
                    timeout    = 1'b1;
                    next_state = IDLE;
                end else begin
                    StallM = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
        if (rst) begin
            next_state = IDLE;
            dmem_req   = 1'b0;
            StallM     = 1'b0;
            done       = 1'b0;
            timeout    = 1'b0;
            misal      = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Wait-cycle counter: held at zero in IDLE so WAIT always starts from 0.
    always_ff @(posedge clk) begin
        if (rst || state == IDLE) cnt <= 16'd0;
        else                      cnt <= cnt + 16'd1;
    end

    // MEM/WB register: bubble while stalled, exceptions suppress the write.
    always_ff @(posedge clk) begin
        if (rst || StallM) begin
            AluoutW    <= 32'd0;
            ReadDataW  <= 32'd0;
            rdW        <= 5'd0;
            RegWriteW  <= 1'b0;
            ResultSrcW <= 1'b0;
            ExcW       <= 1'b0;
            ExcCauseW  <= 2'b00;
        end else begin
            AluoutW    <= AluoutM;
            ReadDataW  <= (done && is_load) ? load_ext : 32'd0;
            rdW        <= rdM;
            RegWriteW  <= RegWriteM & ~(misal | timeout);
            ResultSrcW <= ResultSrcM;
            ExcW       <= misal | timeout;
            ExcCauseW  <= {timeout, misal};
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus randomized instructions,
// checked against a per-instruction reference model.
module tb_mem_stage;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] AluoutM, Mem_dataM, dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] AluoutW, ReadDataW;
    logic [4:0]  rdM, rdW;
    logic        RegWriteM, ResultSrcM, MemWriteM;
    logic [2:0]  funct3M;
    logic        dmem_req, dmem_we, dmem_ready, StallM;
    logic [3:0]  dmem_wstrb;
    logic        RegWriteW, ResultSrcW, ExcW;
    logic [1:0]  ExcCauseW;

    int passed = 0;
    int total  = 0;

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .AluoutM(AluoutM), .Mem_dataM(Mem_dataM),
        .rdM(rdM), .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM),
        .MemWriteM(MemWriteM), .funct3M(funct3M), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .StallM(StallM), .AluoutW(AluoutW),
        .ReadDataW(ReadDataW), .rdW(rdW), .RegWriteW(RegWriteW),
        .ResultSrcW(ResultSrcW), .ExcW(ExcW), .ExcCauseW(ExcCauseW)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stall;
        int          reqc;
        logic [73:0] wb;
        logic [68:0] bus;
    } exp_t;

    // Observations from the most recent instruction.
    int          obs_stall, obs_req;
    logic        obs_hold_ok, obs_bubble_ok, obs_hung;
    logic [68:0] obs_bus;
    logic [73:0] obs_wb;

    // Reference: whole-instruction outcome from the architectural rules.
    // Ready is driven only on cycle D (cycle 0 = first cycle in MEM).
    function automatic exp_t model(input logic [31:0] alu, data,
                                   input logic [4:0] rd, input logic regw, rs, mw,
                                   input logic [2:0] f3, input int d,
                                   input logic [31:0] rdata);
        exp_t        e;
        int          sz, off, fin;
        logic [31:0] val, mask, wd;
        logic [3:0]  strb;
        logic        exc, wr;
        logic [1:0]  cause;
        sz  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        off = int'(alu[1:0]);
        val = 0; exc = 0; cause = 0; wr = regw; e.stall = 0; e.reqc = 0;
        if (rs || mw) begin
            if (off % sz != 0) begin
                exc = 1; cause = 2'd1; wr = 0;
            end else begin
                fin = (d < T) ? d : T;
                e.stall = fin;
                e.reqc  = fin + 1;
                if (d > T) begin
                    exc = 1; cause = 2'd2; wr = 0;
                end else if (rs && !mw) begin
                    val = rdata >> (8 * off);
                    if (sz < 4) begin
                        mask = (32'd1 << (8 * sz)) - 32'd1;
                        val  = val & mask;
                        if (!f3[2] && val[8*sz-1]) val = val | ~mask;
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            wd[8*i +: 8] = data[8*(i % sz) +: 8];
            strb[i]      = mw && (i >= off) && (i < off + sz);
        end
        e.bus = {mw, alu[31:2], 2'b00, wd, strb};
        e.wb  = {alu, val, rd, wr, rs, exc, cause};
        return e;
    endfunction

    // Drive one instruction into MEM and record what the DUT did with it.
    task automatic run_instr(input logic [31:0] alu, data, input logic [4:0] rd,
                             input logic regw, rs, mw, input logic [2:0] f3,
                             input int d, input logic [31:0] rdata);
        logic done, st;
        AluoutM = alu; Mem_dataM = data; rdM = rd; RegWriteM = regw;
        ResultSrcM = rs; MemWriteM = mw; funct3M = f3; dmem_rdata = rdata;
        obs_stall = 0; obs_req = 0; obs_hold_ok = 1; obs_bubble_ok = 1;
        obs_bus = '0; obs_wb = '0; done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            dmem_ready = (c == d);
            @(negedge clk);
            if (dmem_req) begin
                if (obs_req == 0) obs_bus = {dmem_we, dmem_addr, dmem_wdata, dmem_wstrb};
                else if (obs_bus !== {dmem_we, dmem_addr, dmem_wdata, dmem_wstrb}) obs_hold_ok = 0;
                obs_req++;
            end
            st = StallM;
            if (st) obs_stall++;
            @(posedge clk); #1;
            if (st) begin
                if (RegWriteW !== 1'b0 || ExcW !== 1'b0) obs_bubble_ok = 0;
            end else begin
                obs_wb = {AluoutW, ReadDataW, rdW, RegWriteW, ResultSrcW, ExcW, ExcCauseW};
                done = 1;
            end
        end
        obs_hung   = !done;
        dmem_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; AluoutM = 32'h40; ResultSrcM = 1; MemWriteM = 0; funct3M = 3'b010;
        RegWriteM = 1; dmem_ready = 1;
        @(negedge clk);
        total++;
        if (dmem_req !== 1'b0 || StallM !== 1'b0) $display("FAIL reset_req_stall: got req=%b stall=%b, want 0 0", dmem_req, StallM);
        else passed++;
        @(posedge clk); #1;
        total++;
        if ({AluoutW, ReadDataW, rdW, RegWriteW, ResultSrcW, ExcW, ExcCauseW} !== 74'd0)
            $display("FAIL reset_wb: got %h want 0", {AluoutW, ReadDataW, rdW, RegWriteW, ResultSrcW, ExcW, ExcCauseW});
        else passed++;
        rst = 0; dmem_ready = 0;
    endtask

    task automatic test_alu();
        exp_t e;
        run_instr(32'h1234, 32'h0, 5'd5, 1, 0, 0, 3'b000, 0, 32'h0);
        e = model(32'h1234, 32'h0, 5'd5, 1, 0, 0, 3'b000, 0, 32'h0);
        total++;
        if (obs_wb !== e.wb) $display("FAIL alu_wb: got %h want %h", obs_wb, e.wb); else passed++;
        total++;
        if (obs_stall != 0 || obs_req != 0) $display("FAIL alu_nostall: got stall=%0d req=%0d want 0 0", obs_stall, obs_req); else passed++;
        total++;
        if (AluoutW !== 32'h1234 || rdW !== 5'd5 || RegWriteW !== 1'b1)
            $display("FAIL alu_fields: got %h/%0d/%b want 1234/5/1", AluoutW, rdW, RegWriteW);
        else passed++;
    endtask

    task automatic test_store_byte();
        exp_t e;
        run_instr(32'h103, 32'hAABBCCDD, 5'd0, 0, 0, 1, 3'b000, 0, 32'h0);
        e = model(32'h103, 32'hAABBCCDD, 5'd0, 0, 0, 1, 3'b000, 0, 32'h0);
        total++;
        if (obs_bus !== {1'b1, 32'h100, 32'hDDDDDDDD, 4'b1000}) $display("FAIL sb_bus: got %h want %h", obs_bus, {1'b1, 32'h100, 32'hDDDDDDDD, 4'b1000}); else passed++;
        total++;
        if (obs_bus !== e.bus || obs_wb !== e.wb) $display("FAIL sb_model: got %h %h want %h %h", obs_bus, obs_wb, e.bus, e.wb); else passed++;
        total++;
        if (obs_stall != 0 || obs_req != 1) $display("FAIL sb_handshake: got stall=%0d req=%0d want 0 1", obs_stall, obs_req); else passed++;
    endtask

    task automatic test_load_half();
        for (int v = 0; v < 2; v++) begin
            logic [2:0] f3;
            exp_t e;
            f3 = (v == 0) ? 3'b001 : 3'b101;
            run_instr(32'h202, 32'h0, 5'd7, 1, 1, 0, f3, 3, 32'h80011234);
            e = model(32'h202, 32'h0, 5'd7, 1, 1, 0, f3, 3, 32'h80011234);
            total++;
            if (obs_stall != 3) $display("FAIL lh_stall: got %0d want 3", obs_stall); else passed++;
            total++;
            if (ReadDataW !== ((v == 0) ? 32'hFFFF8001 : 32'h00008001))
                $display("FAIL lh_data: got %h want %h", ReadDataW, (v == 0) ? 32'hFFFF8001 : 32'h00008001);
            else passed++;
            total++;
            if (obs_wb !== e.wb || obs_bus !== e.bus || !obs_hold_ok || !obs_bubble_ok)
                $display("FAIL lh_model: got %h %h hold=%b bubble=%b want %h %h", obs_wb, obs_bus, obs_hold_ok, obs_bubble_ok, e.wb, e.bus);
            else passed++;
        end
    endtask

    task automatic test_misaligned();
        run_instr(32'h301, 32'h0, 5'd9, 1, 1, 0, 3'b010, 0, 32'h12345678);
        total++;
        if (obs_req != 0 || obs_stall != 0) $display("FAIL mis_noreq: got req=%0d stall=%0d want 0 0", obs_req, obs_stall); else passed++;
        total++;
        if (ExcW !== 1'b1 || ExcCauseW !== 2'b01 || RegWriteW !== 1'b0)
            $display("FAIL mis_exc: got exc=%b cause=%b we=%b want 1 01 0", ExcW, ExcCauseW, RegWriteW);
        else passed++;
    endtask

    task automatic test_timeout();
        exp_t e;
        run_instr(32'h400, 32'h0, 5'd3, 1, 1, 0, 3'b010, 100, 32'h0);
        e = model(32'h400, 32'h0, 5'd3, 1, 1, 0, 3'b010, 100, 32'h0);
        total++;
        if (obs_req != T + 1 || obs_stall != T) $display("FAIL to_cycles: got req=%0d stall=%0d want %0d %0d", obs_req, obs_stall, T + 1, T); else passed++;
        total++;
        if (obs_wb !== e.wb || ExcCauseW !== 2'b10) $display("FAIL to_wb: got %h want %h", obs_wb, e.wb); else passed++;
        run_instr(32'h55, 32'h0, 5'd1, 1, 0, 0, 3'b000, 0, 32'h0);
        total++;
        if (ExcW !== 1'b0 || RegWriteW !== 1'b1) $display("FAIL to_pulse: got exc=%b we=%b want 0 1", ExcW, RegWriteW); else passed++;
        // Ready on the final WAIT cycle completes normally.
        run_instr(32'h408, 32'h0, 5'd4, 1, 1, 0, 3'b010, T, 32'hCAFEF00D);
        e = model(32'h408, 32'h0, 5'd4, 1, 1, 0, 3'b010, T, 32'hCAFEF00D);
        total++;
        if (obs_wb !== e.wb || ExcW !== 1'b0) $display("FAIL to_limit_wins: got %h want %h", obs_wb, e.wb); else passed++;
    endtask

    task automatic test_reset_in_wait();
        exp_t e;
        AluoutM = 32'h500; ResultSrcM = 1; MemWriteM = 0; funct3M = 3'b010;
        RegWriteM = 1; rdM = 5'd2; dmem_ready = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        total++;
        if (dmem_req !== 1'b0 || StallM !== 1'b0) $display("FAIL rw_drop: got req=%b stall=%b want 0 0", dmem_req, StallM); else passed++;
        @(posedge clk); #1;
        total++;
        if ({AluoutW, ReadDataW, rdW, RegWriteW, ResultSrcW, ExcW, ExcCauseW} !== 74'd0)
            $display("FAIL rw_wb: got %h want 0", {AluoutW, ReadDataW, rdW, RegWriteW, ResultSrcW, ExcW, ExcCauseW});
        else passed++;
        rst = 0;
        run_instr(32'h77, 32'h0, 5'd6, 1, 0, 0, 3'b000, 0, 32'h0);
        e = model(32'h77, 32'h0, 5'd6, 1, 0, 0, 3'b000, 0, 32'h0);
        total++;
        if (obs_req != 0 || obs_wb !== e.wb) $display("FAIL rw_idle: got req=%0d wb=%h want 0 %h", obs_req, obs_wb, e.wb); else passed++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] alu, data, rdata;
            logic [4:0]  rd;
            logic        regw, rs, mw;
            logic [2:0]  f3;
            int          d, kind;
            exp_t        e;
            alu = $urandom; data = $urandom; rdata = $urandom; rd = 5'($urandom);
            regw = 1'($urandom); f3 = 3'($urandom); d = $urandom_range(0, T + 2);
            kind = $urandom_range(0, 3);
            rs = (kind == 1 || kind == 3);
            mw = (kind == 2 || kind == 3);
            if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
            run_instr(alu, data, rd, regw, rs, mw, f3, d, rdata);
            e = model(alu, data, rd, regw, rs, mw, f3, d, rdata);
            total++;
            if (obs_hung) $display("FAIL rnd_hung: instr %0d never left MEM", n); else passed++;
            total++;
            if (obs_wb !== e.wb) $display("FAIL rnd_wb: instr %0d got %h want %h", n, obs_wb, e.wb); else passed++;
            total++;
            if (obs_stall != e.stall || obs_req != e.reqc)
                $display("FAIL rnd_timing: instr %0d got stall=%0d req=%0d want %0d %0d", n, obs_stall, obs_req, e.stall, e.reqc);
            else passed++;
            if (e.reqc > 0) begin
                total++;
                if (obs_bus !== e.bus || !obs_hold_ok) $display("FAIL rnd_bus: instr %0d got %h hold=%b want %h", n, obs_bus, obs_hold_ok, e.bus); else passed++;
            end
            total++;
            if (!obs_bubble_ok) $display("FAIL rnd_bubble: instr %0d W write/exc seen during stall", n); else passed++;
        end
    endtask

    initial begin
        rst = 1; AluoutM = 0; Mem_dataM = 0; rdM = 0; RegWriteM = 0;
        ResultSrcM = 0; MemWriteM = 0; funct3M = 0; dmem_ready = 0; dmem_rdata = 0;
        @(posedge clk); #1;
        test_reset();
        test_alu();
        test_store_byte();
        test_load_half();
        test_misaligned();
        test_timeout();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
